// File: rtl/codec_rst_pkg.sv
// Shared types and default constants for the codec reset/configuration sequencer.
package codec_rst_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HOLD   = 3'd1,
        SETTLE = 3'd2,
        CFG    = 3'd3,
        READY  = 3'd4,
        ERR    = 3'd5
    } seq_state_t;

    localparam int DEF_HOLD_CYC    = 1000;
    localparam int DEF_SETTLE_CYC  = 2000;
    localparam int DEF_TIMEOUT_CYC = 65535;
    localparam int DEF_MAX_RETRY   = 3;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/codec_rst_seq_cyc_timer.sv
// Loadable down-counter; done is high while the count is zero. Saturates at zero.
module cyc_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of its inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/codec_rst_seq.sv
// Codec power-up sequencer: reset hold, settle, configuration handshake.
// Optional CFG timeout/retry/error path enabled by defining CODEC_RST_SEQ_TIMEOUT_EN.
module codec_rst_seq
    import codec_rst_pkg::*;
#(
    parameter int HOLD_CYC    = DEF_HOLD_CYC,
    parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_done,
    input  logic       soft_restart,
    output logic       codec_rst_n,
    output logic       cfg_start,
    output logic       sys_ready,
    output logic       seq_err,
    output logic [2:0] state_o
);

    localparam int MAX_CYC = max_of(max_of(HOLD_CYC, SETTLE_CYC), TIMEOUT_CYC);
    localparam int CW      = $clog2(MAX_CYC + 1);

    seq_state_t    state;
    seq_state_t    next_state;
    logic          restart_req;
    logic          tmr_load;
    logic [CW-1:0] tmr_load_val;
    logic          tmr_done;

`ifdef CODEC_RST_SEQ_TIMEOUT_EN
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    logic [RW-1:0] retry;
    logic [RW-1:0] retry_next;
`endif

    assign restart_req = soft_restart && (state != IDLE);

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        next_state = state;
`ifdef CODEC_RST_SEQ_TIMEOUT_EN
        retry_next = retry;
`endif
        if (restart_req) begin
            next_state = HOLD;
`ifdef CODEC_RST_SEQ_TIMEOUT_EN
            retry_next = '0;
`endif
        end else begin
            case (state)
                IDLE:   next_state = HOLD;
                HOLD:   if (tmr_done) next_state = SETTLE;
                SETTLE: if (tmr_done) next_state = CFG;
                CFG: begin
                    // cfg_start is high only on the first CFG cycle; cfg_done is not trusted there.
                    if (!cfg_start && cfg_done) begin
                        next_state = READY;
                    end
`ifdef CODEC_RST_SEQ_TIMEOUT_EN
                    else if (tmr_done) begin
                        if (retry < RW'(MAX_RETRY)) begin
                            next_state = HOLD;
                            retry_next = retry + RW'(1);
                        end else begin
                            next_state = ERR;
                        end
                    end
`endif
                end
                READY:   next_state = READY;
                ERR:     next_state = ERR;
                default: next_state = IDLE;
            endcase
        end
    end

    // The timer is reloaded on every state entry, including a restart into HOLD.
    always_comb begin
        tmr_load     = (next_state != state) || restart_req;
        tmr_load_val = '0;
        case (next_state)
            HOLD:   tmr_load_val = CW'(HOLD_CYC - 1);
            SETTLE: tmr_load_val = CW'(SETTLE_CYC - 1);
`ifdef CODEC_RST_SEQ_TIMEOUT_EN
            CFG:    tmr_load_val = CW'(TIMEOUT_CYC - 1);
`endif
            default: tmr_load_val = '0;
        endcase
    end

    cyc_timer #(
        .W        (CW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .done     (tmr_done)
    );

    // Outputs are registered from next_state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            codec_rst_n <= 1'b0;
            cfg_start   <= 1'b0;
            sys_ready   <= 1'b0;
        end else begin
            state       <= next_state;
            codec_rst_n <= (next_state == SETTLE) || (next_state == CFG) ||
                           (next_state == READY);
            cfg_start   <= (next_state == CFG) && (state != CFG);
            sys_ready   <= (next_state == READY);
        end
    end

`ifdef CODEC_RST_SEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            retry   <= '0;
            seq_err <= 1'b0;
        end else begin
            retry   <= retry_next;
            seq_err <= (next_state == ERR);
        end
    end
`else
    assign seq_err = 1'b0;
`endif

    assign state_o = state;

endmodule

// File: doc/codec_rst_seq.md
CODEC_RST_SEQ -- requirements
Module: codec_rst_seq

Interface
REQ-001 SHALL have parameter HOLD_CYC, default 1000: cycles codec_rst_n is held low.
REQ-002 SHALL have parameter SETTLE_CYC, default 2000: cycles waited after codec_rst_n release.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 65535: cycles allowed for cfg_done.
REQ-004 SHALL have parameter MAX_RETRY, default 3: retries after timeout.
REQ-005 SHALL have port clk, input, 1, system clock; one clock only, all logic on posedge clk.
REQ-006 SHALL have port rst, input, 1, reset, synchronous and active-high; driven from the synchronized board reset.
REQ-007 SHALL have port cfg_done, input, 1, codec configuration complete (level).
REQ-008 SHALL have port soft_restart, input, 1, single-cycle request to re-run the sequence.
REQ-009 SHALL have port codec_rst_n, output, 1, active-low codec reset.
REQ-010 SHALL have port cfg_start, output, 1, single-cycle configuration start pulse.
REQ-011 SHALL have port sys_ready, output, 1, sequence complete; equalizer datapath may run.
REQ-012 SHALL have port seq_err, output, 1, retries exhausted.
REQ-013 SHALL have port state_o, output, 3, current state encoding.

Function
REQ-014 SHALL implement states IDLE, HOLD, SETTLE, CFG, READY, ERR; all outputs registered.
REQ-015 IDLE SHALL last one cycle after rst deasserts, then go to HOLD.
REQ-016 HOLD SHALL drive codec_rst_n=0 for exactly HOLD_CYC cycles, then go to SETTLE.
REQ-017 SETTLE SHALL drive codec_rst_n=1 for exactly SETTLE_CYC cycles, then go to CFG.
REQ-018 cfg_start SHALL be 1 only on the first cycle of each CFG entry.
REQ-019 cfg_done SHALL be sampled in CFG only from the cycle after cfg_start; when sampled high, go to READY; ignored in all other states.
REQ-020 READY SHALL assert sys_ready=1 on its first cycle; it stays high until rst or soft_restart.
REQ-021 soft_restart in any state other than IDLE SHALL force HOLD next cycle, clear sys_ready, seq_err, and the retry count, and restart counters.
REQ-022 soft_restart and cfg_done in the same cycle SHALL resolve as soft_restart.
REQ-023 Counters SHALL be wide enough for the largest parameter; zero parameter values are illegal; counters SHALL NOT wrap.

Reset
REQ-024 rst high SHALL force IDLE, codec_rst_n=0, cfg_start=0, sys_ready=0, seq_err=0, retry count=0, counters=0 on the next edge, including mid-sequence.
REQ-025 rst SHALL take priority over soft_restart and cfg_done.

Configuration
REQ-026 With CODEC_RST_SEQ_TIMEOUT_EN defined: CFG expiry after TIMEOUT_CYC cycles without cfg_done SHALL increment retry and go to HOLD if retry<MAX_RETRY; otherwise go to ERR.
REQ-027 ERR SHALL drive codec_rst_n=0 and seq_err=1, and exit only on rst or soft_restart.
REQ-028 cfg_done and timeout expiry in the same cycle SHALL resolve as cfg_done (READY).
REQ-029 Without CODEC_RST_SEQ_TIMEOUT_EN: CFG SHALL wait indefinitely, ERR is unreachable, seq_err is tied 0, and there is no timeout or retry logic.

Structure
REQ-030 A shared package codec_rst_pkg SHALL hold the state enum (IDLE=0 ... ERR=5) and the default parameter constants.
REQ-031 One sub-module, cyc_timer, SHALL be used: a loadable down-counter with a done flag, shared across HOLD, SETTLE, and CFG.

Verification (bench parameters HOLD_CYC=4, SETTLE_CYC=3, TIMEOUT_CYC=10, MAX_RETRY=2)
REQ-032 Nominal: release rst, cfg_done high 5 cycles after cfg_start -> codec_rst_n low 4 cycles, high 3 cycles, one cfg_start pulse, sys_ready 1 cycle after cfg_done is sampled.
REQ-033 Timeout (macro on): cfg_done held low -> 3 cfg_start pulses, then ERR with seq_err=1 and codec_rst_n=0; soft_restart -> HOLD, seq_err=0.
REQ-034 Same-cycle events: cfg_done on the timeout-expiry cycle -> READY with no retry; soft_restart with cfg_done -> HOLD.
REQ-035 Reset mid-SETTLE: rst pulsed 1 cycle -> IDLE, then the full HOLD of 4 cycles repeats; no cfg_start pulse is issued early.
REQ-036 Macro off: cfg_done low for 100 cycles -> remains in CFG, seq_err=0, a single cfg_start pulse.
